// File: rtl/polar_pkg.sv
// polar_pkg: shared types and constants for the polar-SC stage sequencer.
// Holds the op encoding, LLR limits and the latched command bundle.
package polar_pkg;

    typedef enum logic [1:0] {
        POLAR_F    = 2'd0,
        POLAR_G    = 2'd1,
        POLAR_R    = 2'd2,
        POLAR_RSVD = 2'd3
    } polar_op_e;

    localparam int LLR_W = 8;
    localparam logic [LLR_W-1:0] LLR_MAX = 8'h7F;
    localparam logic [LLR_W-1:0] LLR_MIN = 8'h81;

    localparam int N_MAX_LOG = 5;
    localparam int MASK_W    = 1 << N_MAX_LOG;

    typedef struct packed {
        polar_op_e         op;
        logic [2:0]        len;
        logic [MASK_W-1:0] mask;
    } polar_cmd_t;

    // Stage lengths above the supported maximum are folded onto it.
    function automatic logic [2:0] clamp_len(
        input logic [2:0] len,
        input logic [2:0] max_log
    );
        return (len > max_log) ? max_log : len;
    endfunction

endpackage

// File: rtl/polar_fgr_unit.sv
// polar_fgr_unit: combinational F/G/R kernel for one LLR pair.
// Produces the result byte and a flag for G saturation events.
module polar_fgr_unit
    import polar_pkg::*;
(
    input  polar_op_e        op,
    input  logic [LLR_W-1:0] a,
    input  logic [LLR_W-1:0] b,
    input  logic             mask_bit,
    output logic [LLR_W-1:0] res,
    output logic             sat
);

    logic [LLR_W-1:0] mag_a;
    logic [LLR_W-1:0] mag_b;
    logic [LLR_W-1:0] mag;
    logic             f_sign;
    logic [LLR_W:0]   g_sum;
    logic             g_hi;
    logic             g_lo;

    // F min-sum, G add/sub with saturation, R hard decision.
    always_comb begin
        mag_a  = a[LLR_W-1] ? (~a + 8'd1) : a;
        mag_b  = b[LLR_W-1] ? (~b + 8'd1) : b;
        mag    = (mag_a < mag_b) ? mag_a : mag_b;
        f_sign = a[LLR_W-1] ^ b[LLR_W-1];
        g_sum  = mask_bit
               ? ({b[LLR_W-1], b} - {a[LLR_W-1], a})
               : ({b[LLR_W-1], b} + {a[LLR_W-1], a});
        g_hi   = $signed(g_sum) > 9'sd127;
        g_lo   = $signed(g_sum) < -9'sd127;
        res    = '0;
        sat    = 1'b0;
        unique case (1'b1)
            (op == POLAR_F): begin
                res = f_sign ? (~mag + 8'd1) : mag;
            end
            (op == POLAR_G): begin
                sat = g_hi | g_lo;
                if (g_hi) begin
                    res = LLR_MAX;
                end else if (g_lo) begin
                    res = LLR_MIN;
                end else begin
                    res = g_sum[LLR_W-1:0];
                end
            end
            (op == POLAR_R): begin
                res = {7'b0, ~mask_bit & a[LLR_W-1]};
            end
            default: begin
                res = '0;
            end
        endcase
    end

endmodule

// File: rtl/polar_stage_sched.sv
// polar_stage_sched: runs one F/G/R stage over N LLR pairs, one per cycle.
// Define POLAR_SAT_STATS_EN to build the G saturation-event counter.
module polar_stage_sched
    import polar_pkg::*;
#(
    parameter int MAX_LOG_N = N_MAX_LOG,
    parameter int SAT_CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_op_i,
    input  logic [2:0]              cmd_len_i,
    input  logic [2**MAX_LOG_N-1:0] cmd_mask_i,
    input  logic                    llr_valid_i,
    output logic                    llr_ready_o,
    input  logic [LLR_W-1:0]        llr_a_i,
    input  logic [LLR_W-1:0]        llr_b_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [LLR_W-1:0]        res_llr_o,
    output logic                    res_last_o,
    output logic                    busy_o,
    output logic [SAT_CNT_W-1:0]    sat_cnt_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e               state_q;
    state_e               state_d;
    polar_cmd_t           cmd_q;
    logic [MAX_LOG_N-1:0] idx_q;
    logic [MAX_LOG_N-1:0] last_idx;
    logic                 is_last;
    logic                 pair_ok;
    logic                 cmd_fire;
    logic                 llr_fire;
    logic [2:0]           len_in;
    logic [LLR_W-1:0]     fgr_res;
    logic                 fgr_sat;
    logic                 res_valid_q;
    logic [LLR_W-1:0]     res_llr_q;
    logic                 res_last_q;

    assign len_in   = clamp_len(cmd_len_i, 3'(MAX_LOG_N));
    assign last_idx = MAX_LOG_N'((32'd1 << cmd_q.len) - 32'd1);
    assign is_last  = (idx_q == last_idx);
    assign pair_ok  = res_ready_i | ~res_valid_q;
    assign cmd_fire = cmd_valid_i & cmd_ready_o;
    assign llr_fire = llr_valid_i & llr_ready_o;

    polar_fgr_unit u_fgr (
        .op       (cmd_q.op),
        .a        (llr_a_i),
        .b        (llr_b_i),
        .mask_bit (cmd_q.mask[idx_q]),
        .res      (fgr_res),
        .sat      (fgr_sat)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshakes; a new command may chain on the last pair.
    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        llr_ready_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                llr_ready_o = pair_ok;
                if (llr_valid_i && pair_ok && is_last) begin
                    cmd_ready_o = 1'b1;
                    state_d     = cmd_valid_i ? S_RUN : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Command latch and element index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q <= '0;
            idx_q <= '0;
        end else if (cmd_fire) begin
            cmd_q.op   <= polar_op_e'(cmd_op_i);
            cmd_q.len  <= len_in;
            cmd_q.mask <= MASK_W'(cmd_mask_i);
            idx_q      <= '0;
        end else if (llr_fire) begin
            idx_q <= idx_q + MAX_LOG_N'(1);
        end
    end

    // Single output register, refilled in the same cycle it drains.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_q <= 1'b0;
            res_llr_q   <= '0;
            res_last_q  <= 1'b0;
        end else if (llr_fire) begin
            res_valid_q <= 1'b1;
            res_llr_q   <= fgr_res;
            res_last_q  <= is_last;
        end else if (res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_llr_o   = res_llr_q;
    assign res_last_o  = res_last_q;
    assign busy_o      = (state_q != S_IDLE) | res_valid_q;

`ifdef POLAR_SAT_STATS_EN
    logic [SAT_CNT_W-1:0] sat_cnt_q;

    // Per-command G saturation count, sticking at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_cnt_q <= '0;
        end else if (cmd_fire) begin
            sat_cnt_q <= '0;
        end else if (llr_fire && fgr_sat && !(&sat_cnt_q)) begin
            sat_cnt_q <= sat_cnt_q + SAT_CNT_W'(1);
        end
    end

    assign sat_cnt_o = sat_cnt_q;
`else
    logic unused_sat;

    assign unused_sat = fgr_sat;
    assign sat_cnt_o  = '0;
`endif

endmodule
